// File: rtl/mm_s2mm_loader.sv
// Splits a 2*M*M-beat AXI-stream frame into the A buffer (first M*M beats), then B. Write strobes trail the beat by 1 cycle.
// tready is registered and drops while both buffers are full; it returns the cycle after done_ack.
// MM_LOADER_TLAST_CHECK_EN adds tlast framing checks with early/missing error pulses.
module mm_s2mm_loader #(
    parameter  int D_W = 8,
    parameter  int M   = 8,
    localparam int AW  = $clog2(M*M)
) (
    input  logic           mm_clk,
    input  logic           mm_rst_n,
    input  logic           s_axis_s2mm_tvalid,
    input  logic [31:0]    s_axis_s2mm_tdata,
    input  logic           s_axis_s2mm_tlast,
    output logic           s_axis_s2mm_tready,
    output logic           a_wr_en,
    output logic [AW-1:0]  a_wr_addr,
    output logic [D_W-1:0] a_wr_data,
    output logic           b_wr_en,
    output logic [AW-1:0]  b_wr_addr,
    output logic [D_W-1:0] b_wr_data,
    output logic           load_done,
    input  logic           done_ack,
    output logic           err_early_last,
    output logic           err_missing_last
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = AW'(M*M-1);

    state_t         state_q;
    logic [AW-1:0]  cnt_q;
    logic [AW-1:0]  cnt_d;
    logic           tready_q;
    logic           a_wr_en_q;
    logic [AW-1:0]  a_wr_addr_q;
    logic [D_W-1:0] a_wr_data_q;
    logic           b_wr_en_q;
    logic [AW-1:0]  b_wr_addr_q;
    logic [D_W-1:0] b_wr_data_q;
    logic           load_done_q;
    logic           beat_acc;
    logic           cnt_last;
    logic           unused_bits;

    assign beat_acc    = s_axis_s2mm_tvalid && tready_q;
    assign cnt_last    = (cnt_q == CNT_LAST);
    assign cnt_d       = cnt_last ? '0 : cnt_q + AW'(1);
    // Only the low operand bits are stored; tlast is also unused when the check is compiled out.
    assign unused_bits = ^{s_axis_s2mm_tdata[31:D_W], s_axis_s2mm_tlast};

`ifdef MM_LOADER_TLAST_CHECK_EN
    logic err_early_q;
    logic err_missing_q;
`endif

    always_ff @(posedge mm_clk or negedge mm_rst_n) begin
        if (!mm_rst_n) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            tready_q    <= 1'b0;
            a_wr_en_q   <= 1'b0;
            a_wr_addr_q <= '0;
            a_wr_data_q <= '0;
            b_wr_en_q   <= 1'b0;
            b_wr_addr_q <= '0;
            b_wr_data_q <= '0;
            load_done_q <= 1'b0;
`ifdef MM_LOADER_TLAST_CHECK_EN
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
`endif
        end else begin
            a_wr_en_q <= 1'b0;
            b_wr_en_q <= 1'b0;
`ifdef MM_LOADER_TLAST_CHECK_EN
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
`endif
            case (state_q)
                LOAD_A: begin
                    tready_q <= 1'b1;
                    if (beat_acc) begin
                        a_wr_en_q   <= 1'b1;
                        a_wr_addr_q <= cnt_q;
                        a_wr_data_q <= s_axis_s2mm_tdata[D_W-1:0];
                        cnt_q       <= cnt_d;
                        if (cnt_last) state_q <= LOAD_B;
`ifdef MM_LOADER_TLAST_CHECK_EN
                        // Any tlast inside the A half is premature: keep the beat, restart the frame.
                        if (s_axis_s2mm_tlast) begin
                            err_early_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= LOAD_A;
                        end
`endif
                    end
                end
                LOAD_B: begin
                    tready_q <= 1'b1;
                    if (beat_acc) begin
                        b_wr_en_q   <= 1'b1;
                        b_wr_addr_q <= cnt_q;
                        b_wr_data_q <= s_axis_s2mm_tdata[D_W-1:0];
                        cnt_q       <= cnt_d;
                        if (cnt_last) begin
                            state_q  <= DONE;
                            tready_q <= 1'b0;
                        end
`ifdef MM_LOADER_TLAST_CHECK_EN
                        if (cnt_last && !s_axis_s2mm_tlast) err_missing_q <= 1'b1;
                        if (!cnt_last && s_axis_s2mm_tlast) begin
                            err_early_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= LOAD_A;
                        end
`endif
                    end
                end
                DONE: begin
                    // First DONE cycle carries the final B strobe, so load_done lands one cycle later.
                    tready_q    <= 1'b0;
                    load_done_q <= 1'b1;
                    if (done_ack) begin
                        state_q     <= LOAD_A;
                        tready_q    <= 1'b1;
                        load_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= LOAD_A;
                    cnt_q       <= '0;
                    tready_q    <= 1'b0;
                    load_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_s2mm_tready = tready_q;
    assign a_wr_en            = a_wr_en_q;
    assign a_wr_addr          = a_wr_addr_q;
    assign a_wr_data          = a_wr_data_q;
    assign b_wr_en            = b_wr_en_q;
    assign b_wr_addr          = b_wr_addr_q;
    assign b_wr_data          = b_wr_data_q;
    assign load_done          = load_done_q;

`ifdef MM_LOADER_TLAST_CHECK_EN
    assign err_early_last   = err_early_q;
    assign err_missing_last = err_missing_q;
`else
    assign err_early_last   = 1'b0;
    assign err_missing_last = 1'b0;
`endif

endmodule

// File: tb/tb_mm_s2mm_loader.sv
// Directed bench for mm_s2mm_loader (D_W=8, M=8): vector table for the first beats, then frame-level sequences.
module tb_mm_s2mm_loader;

    localparam int D_W = 8;
    localparam int M   = 8;
    localparam int AW  = 6;
`ifdef MM_LOADER_TLAST_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic           mm_clk = 1'b0;
    logic           mm_rst_n = 1'b0;
    logic           tvalid = 1'b0;
    logic [31:0]    tdata = '0;
    logic           tlast = 1'b0;
    logic           tready;
    logic           a_wr_en, b_wr_en;
    logic [AW-1:0]  a_wr_addr, b_wr_addr;
    logic [D_W-1:0] a_wr_data, b_wr_data;
    logic           load_done;
    logic           done_ack = 1'b0;
    logic           err_early_last, err_missing_last;

    mm_s2mm_loader #(.D_W(D_W), .M(M)) dut (
        .mm_clk            (mm_clk),
        .mm_rst_n          (mm_rst_n),
        .s_axis_s2mm_tvalid(tvalid),
        .s_axis_s2mm_tdata (tdata),
        .s_axis_s2mm_tlast (tlast),
        .s_axis_s2mm_tready(tready),
        .a_wr_en           (a_wr_en),
        .a_wr_addr         (a_wr_addr),
        .a_wr_data         (a_wr_data),
        .b_wr_en           (b_wr_en),
        .b_wr_addr         (b_wr_addr),
        .b_wr_data         (b_wr_data),
        .load_done         (load_done),
        .done_ack          (done_ack),
        .err_early_last    (err_early_last),
        .err_missing_last  (err_missing_last)
    );

    always #5 mm_clk = ~mm_clk;

    int nchk = 0;
    int nbad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: logs every write strobe and counts error / load_done events.
    int cyc = 0;
    int a_addr_q[$], a_dat_q[$], b_addr_q[$], b_dat_q[$];
    int n_early = 0, n_miss = 0, n_ld_rise = 0, last_b_cyc = 0, ld_rise_cyc = 0;
    bit ld_prev = 1'b0;

    always @(posedge mm_clk) cyc++;

    always @(negedge mm_clk) begin
        if (a_wr_en === 1'b1) begin
            a_addr_q.push_back(int'(a_wr_addr));
            a_dat_q.push_back(int'(a_wr_data));
        end
        if (b_wr_en === 1'b1) begin
            b_addr_q.push_back(int'(b_wr_addr));
            b_dat_q.push_back(int'(b_wr_data));
            last_b_cyc = cyc;
        end
        if (err_early_last === 1'b1) n_early++;
        if (err_missing_last === 1'b1) n_miss++;
        if (load_done === 1'b1 && !ld_prev) begin
            n_ld_rise++;
            ld_rise_cyc = cyc;
        end
        ld_prev = (load_done === 1'b1);
    end

    task automatic tick();
        @(posedge mm_clk);
        #1;
    endtask

    // Entered and left at posedge+1; holds the beat until the DUT takes it.
    task automatic send_beat(input logic [31:0] d, input logic l);
        bit acc;
        int tries;
        tries  = 0;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        do begin
            acc = tready;
            tick();
            tries++;
        end while (!acc && tries < 50);
        if (!acc) chk("beat_accept_timeout", 32'd0, 32'd1);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input int last_idx, input bit gap);
        for (int i = 0; i < nbeats; i++) begin
            send_beat({8'hC3, 16'h0, 8'(i)}, i == last_idx);
            if (gap) tick();
        end
    endtask

    task automatic check_frame(input int ia, input int ib);
        chk("a_strobe_count", a_addr_q.size() - ia, M*M);
        chk("b_strobe_count", b_addr_q.size() - ib, M*M);
        for (int i = 0; i < M*M; i++) begin
            if (ia + i < a_addr_q.size()) begin
                chk("a_addr", a_addr_q[ia+i], i);
                chk("a_data", a_dat_q[ia+i], i);
            end
            if (ib + i < b_addr_q.size()) begin
                chk("b_addr", b_addr_q[ib+i], i);
                chk("b_data", b_dat_q[ib+i], M*M + i);
            end
        end
    endtask

    task automatic do_reset();
        tvalid   = 1'b0;
        tlast    = 1'b0;
        done_ack = 1'b0;
        #2 mm_rst_n = 1'b0;
        @(negedge mm_clk);
        mm_rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic           v;
        logic [31:0]    d;
        logic           en;
        logic [AW-1:0]  addr;
        logic [D_W-1:0] dat;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ia, ib, e0, m0, l0, hi;

        tbl[0] = '{1'b1, 32'h0000_0011, 1'b1, 6'd0, 8'h11};
        tbl[1] = '{1'b0, 32'hFFFF_FF22, 1'b0, 6'd0, 8'h00};
        tbl[2] = '{1'b1, 32'hABCD_EF33, 1'b1, 6'd1, 8'h33};
        tbl[3] = '{1'b1, 32'h0000_0144, 1'b1, 6'd2, 8'h44};
        tbl[4] = '{1'b0, 32'h0000_0055, 1'b0, 6'd0, 8'h00};
        tbl[5] = '{1'b0, 32'h0000_0066, 1'b0, 6'd0, 8'h00};
        tbl[6] = '{1'b1, 32'h5500_00FF, 1'b1, 6'd3, 8'hFF};
        tbl[7] = '{1'b1, 32'hFFFF_FF7F, 1'b1, 6'd4, 8'h7F};

        // Reset state
        repeat (2) @(posedge mm_clk);
        #1;
        chk("rst_tready", tready, 0);
        chk("rst_a_en", a_wr_en, 0);
        chk("rst_b_en", b_wr_en, 0);
        chk("rst_a_addr", a_wr_addr, 0);
        chk("rst_a_data", a_wr_data, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_errs", {err_early_last, err_missing_last}, 0);
        @(negedge mm_clk);
        mm_rst_n = 1'b1;
        tick();
        chk("tready_after_release", tready, 1);

        // Vector table: one registered-latency strobe per accepted beat, upper tdata bits dropped
        for (int i = 0; i < 8; i++) begin
            tvalid = tbl[i].v;
            tdata  = tbl[i].d;
            tick();
            chk("tbl_a_en", a_wr_en, tbl[i].en);
            chk("tbl_b_en", b_wr_en, 0);
            chk("tbl_tready", tready, 1);
            if (tbl[i].en) begin
                chk("tbl_a_addr", a_wr_addr, tbl[i].addr);
                chk("tbl_a_data", a_wr_data, tbl[i].dat);
            end
        end
        do_reset();

        // Full continuous frame with tlast on beat 127
        ia = a_addr_q.size(); ib = b_addr_q.size();
        e0 = n_early; m0 = n_miss; l0 = n_ld_rise;
        send_frame(2*M*M, 2*M*M-1, 1'b0);
        repeat (3) tick();
        check_frame(ia, ib);
        chk("f1_load_done", load_done, 1);
        chk("f1_ld_after_last_b", ld_rise_cyc - last_b_cyc, 1);
        chk("f1_ld_rises", n_ld_rise - l0, 1);
        chk("f1_early", n_early - e0, 0);
        chk("f1_missing", n_miss - m0, 0);
        chk("f1_tready_done", tready, 0);

        // DONE holds off the next frame until done_ack
        ia = a_addr_q.size(); ib = b_addr_q.size();
        tvalid = 1'b1;
        tdata  = 32'h1234_565A;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tready !== 1'b0) hi++;
        end
        chk("done_tready_high_cycles", hi, 0);
        chk("done_no_a_strobes", a_addr_q.size() - ia, 0);
        chk("done_no_b_strobes", b_addr_q.size() - ib, 0);
        chk("done_load_done_held", load_done, 1);
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        chk("ack_load_done_clear", load_done, 0);
        chk("ack_tready", tready, 1);
        chk("ack_no_strobe", a_wr_en, 0);
        tick();
        tvalid = 1'b0;
        chk("next_beat_a_en", a_wr_en, 1);
        chk("next_beat_a_addr", a_wr_addr, 0);
        chk("next_beat_a_data", a_wr_data, 8'h5A);
        do_reset();

        // tvalid toggling every other cycle
        ia = a_addr_q.size(); ib = b_addr_q.size(); l0 = n_ld_rise;
        send_frame(2*M*M, 2*M*M-1, 1'b1);
        repeat (2) tick();
        check_frame(ia, ib);
        chk("gap_ld_rises", n_ld_rise - l0, 1);
        do_reset();

        // tlast on beat 10
        ia = a_addr_q.size(); e0 = n_early; m0 = n_miss; l0 = n_ld_rise;
        send_frame(11, 10, 1'b0);
        send_beat(32'h0000_0077, 1'b0);
        repeat (10) tick();
        chk("early_a_count", a_addr_q.size() - ia, 12);
        if (a_addr_q.size() >= ia + 12) begin
            chk("early_beat10_addr", a_addr_q[ia+10], 10);
            chk("early_beat10_data", a_dat_q[ia+10], 10);
            chk("early_next_addr", a_addr_q[ia+11], CHK ? 0 : 11);
            chk("early_next_data", a_dat_q[ia+11], 8'h77);
        end
        chk("early_err_cycles", n_early - e0, CHK);
        chk("early_missing", n_miss - m0, 0);
        chk("early_no_load_done", n_ld_rise - l0, 0);
        do_reset();

        // Full frame with no tlast on beat 127
        ia = a_addr_q.size(); ib = b_addr_q.size();
        e0 = n_early; m0 = n_miss; l0 = n_ld_rise;
        send_frame(2*M*M, -1, 1'b0);
        repeat (3) tick();
        check_frame(ia, ib);
        chk("miss_err_cycles", n_miss - m0, CHK);
        chk("miss_early", n_early - e0, 0);
        chk("miss_load_done", load_done, 1);
        chk("miss_ld_rises", n_ld_rise - l0, 1);
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        do_reset();

        // Asynchronous reset after beat 40
        send_frame(41, -1, 1'b0);
        chk("pre_rst_a_en", a_wr_en, 1);
        chk("pre_rst_a_addr", a_wr_addr, 40);
        #2 mm_rst_n = 1'b0;
        #1;
        chk("async_rst_a_en", a_wr_en, 0);
        chk("async_rst_a_addr", a_wr_addr, 0);
        chk("async_rst_a_data", a_wr_data, 0);
        chk("async_rst_tready", tready, 0);
        chk("async_rst_b_en", b_wr_en, 0);
        chk("async_rst_load_done", load_done, 0);
        @(negedge mm_clk);
        mm_rst_n = 1'b1;
        tick();
        ia = a_addr_q.size();
        send_beat(32'h0000_0099, 1'b0);
        tick();
        chk("post_rst_a_count", a_addr_q.size() - ia, 1);
        if (a_addr_q.size() > ia) begin
            chk("post_rst_a_addr", a_addr_q[ia], 0);
            chk("post_rst_a_data", a_dat_q[ia], 8'h99);
        end

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
